fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline: owns the PC register, drives the instruction-memory request/acknowledge handshake, and owns the IF/ID pipeline register. It consumes the hazard unit's `pa_pc_ifid` stall and `wash_ifid` flush, along with branch and CP0 redirects. It returns `fetch_pause_o`, which is ORed into the global `pause` while a fetch is outstanding. A single-entry hold buffer keeps an instruction that returns while the pipeline is stalled.

## Interface
- `RESET_PC`, default 32'hBFC0_0000. PC loaded on reset.
- `clk` in, 1. Pipeline clock; all state updates on the rising edge.
- `rst` in, 1. Synchronous, active-high reset.
- `pa_pc_ifid_i` in, 1. Stall: hold the PC and IF/ID.
- `wash_ifid_i` in, 1. Flush IF/ID to a bubble.
- `bpu_redirect_i` in, 1. Branch/jump redirect from ID.
- `bpu_target_i` in, 32. Target for `bpu_redirect_i`.
- `cp0_redirect_i` in, 1. Exception/ERET redirect.
- `cp0_target_i` in, 32. Target for `cp0_redirect_i` (vector or EPC).
- `imem_req_o` out, 1. Fetch request.
- `imem_addr_o` out, 32. Fetch address, equal to the PC.
- `imem_ack_i` in, 1. Single-cycle acknowledge; `imem_rdata_i` is valid in the same cycle.
- `imem_rdata_i` in, 32. Fetched instruction.
- `ifid_instr_o` out, 32. IF/ID instruction.
- `ifid_pc_o` out, 32. IF/ID PC.
- `ifid_valid_o` out, 1. IF/ID holds a real instruction.
- `fetch_pause_o` out, 1. Fetch outstanding; the pipeline must pause.

## Operation
- States:
  - S_FETCH: request outstanding.
  - S_HOLD: instruction buffered, waiting on the stall.
  - S_DRAIN: the outstanding request belongs to a redirected-away PC.
- Redirect sampling:
  - Redirects are sampled only when `pa_pc_ifid_i`=0.
  - Priority: `cp0_redirect_i` > `bpu_redirect_i`.
  - Target is `cp0_target_i` or `bpu_target_i` respectively.
- Bus handshake:
  - `imem_req_o` = (S_FETCH or S_DRAIN) and !`rst`.
  - `imem_addr_o` = PC, held stable until ack.
  - Ack may arrive in the same cycle the request first appears (zero wait).
  - `imem_ack_i` in S_HOLD is ignored.
  - A request cannot be cancelled. After a redirect, the outstanding request is drained and its data discarded.
- S_FETCH with ack, no redirect:
  - `pa_pc_ifid_i`=0: IF/ID <= {rdata, PC, valid 1}; PC <= PC+4; stay in S_FETCH.
  - `pa_pc_ifid_i`=1: buffer <= {rdata, PC}; PC <= PC+4; go to S_HOLD.
- S_FETCH with ack and redirect: discard data; PC <= target; stay in S_FETCH.
- S_FETCH, no ack, redirect: latch target; go to S_DRAIN.
- S_DRAIN on ack: discard data; PC <= latched target; go to S_FETCH.
- S_DRAIN, new redirect before ack: the latched target is overwritten by the new target, using the same priority rule.
- S_HOLD, `pa_pc_ifid_i`=0:
  - No redirect: IF/ID <= buffer with valid 1; go to S_FETCH.
  - Redirect: drop the buffer; PC <= target; go to S_FETCH.
- IF/ID update rules:
  - `pa_pc_ifid_i`=1: IF/ID holds. This has priority over `wash_ifid_i`.
  - Else `wash_ifid_i`=1: IF/ID <= {32'h0, 32'h0, 0}.
  - Else, if no instruction is delivered this cycle: the same bubble.
- PC increment wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- `fetch_pause_o` = (S_FETCH and !`imem_ack_i`) or S_DRAIN. It never depends combinationally on `pa_pc_ifid_i`, so there is no loop through the hazard unit.

## Timing
- Reset values:
  - PC = `RESET_PC`; state = S_FETCH.
  - `ifid_instr_o` = 0, `ifid_pc_o` = 0, `ifid_valid_o` = 0; buffer empty.
  - While `rst`=1: `imem_req_o` = 0 and `fetch_pause_o` = 0.
- Reset mid-operation aborts any pending or held fetch. An ack arriving during reset is ignored.
- First request: the first cycle with `rst`=0, at address `RESET_PC`.
- Zero-wait memory: one instruction per cycle. Latency from request to IF/ID valid is 1 edge.
- N-wait memory: `fetch_pause_o` is high for N cycles per fetch.
- Redirect with a pending request: the new target is requested in the cycle after the drain ack.
- Redirect with the ack in the same cycle: the new target is requested in the next cycle.
- S_HOLD to IF/ID: the held instruction appears on the edge at which the stall drops.

## Test plan
- Reset, zero-wait memory returning addr-derived data:
  - `imem_addr_o` sequence is BFC00000, BFC00004, BFC00008.
  - `ifid_pc_o` lags by one cycle with `ifid_valid_o`=1.
  - `fetch_pause_o`=0 throughout.
- 3-wait memory:
  - `fetch_pause_o` high for 3 cycles per fetch.
  - `imem_addr_o` stable across the wait.
  - IF/ID shows bubbles (valid 0) during the wait.
- Ack at PC 0x100 while `pa_pc_ifid_i`=1 for 4 cycles:
  - State goes to S_HOLD; IF/ID unchanged; `imem_req_o`=0.
  - After the stall drops, IF/ID = {instr@0x100, 0x100, 1}; the next request is to 0x104.
- `bpu_redirect_i` to 0x400 while the fetch at 0x200 has 2 wait cycles left:
  - State goes to S_DRAIN; `fetch_pause_o`=1.
  - 0x200 data is discarded and never appears in IF/ID.
  - Next `imem_addr_o` = 0x400.
- Simultaneous redirects and a flush in one cycle:
  - Inputs: `cp0_redirect_i` (0x80000180), `bpu_redirect_i` (0x500) and `wash_ifid_i`, in the same cycle, with an ack.
  - PC becomes 0x80000180.
  - IF/ID = {0, 0, 0}.
- Two wrap/reset cases:
  - PC 32'hFFFF_FFFC: the next address is 0.
  - `rst` asserted during S_DRAIN: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, imem handshake and IF/ID register.
// A one-entry hold buffer keeps an instruction that returns under a stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pa_pc_ifid_i,
  input  logic        wash_ifid_i,
  input  logic        bpu_redirect_i,
  input  logic [31:0] bpu_target_i,
  input  logic        cp0_redirect_i,
  input  logic [31:0] cp0_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_o,
  output logic        ifid_valid_o,
  output logic        fetch_pause_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] drain_pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        redir;
  logic [31:0] redir_pc;
  logic        deliver;
  logic [31:0] dl_instr;
  logic [31:0] dl_pc;

  assign redir = !pa_pc_ifid_i
               && (cp0_redirect_i || bpu_redirect_i);

  always_comb begin
    redir_pc = bpu_target_i;
    unique case (1'b1)
      cp0_redirect_i: redir_pc = cp0_target_i;
      default:        redir_pc = bpu_target_i;
    endcase
  end

  // What would enter IF/ID this cycle if nothing stalls or flushes it.
  always_comb begin
    deliver  = 1'b0;
    dl_instr = imem_rdata_i;
    dl_pc    = pc;
    unique case (1'b1)
      (state == S_FETCH): deliver = imem_ack_i && !redir;
      (state == S_HOLD): begin
        deliver  = !redir;
        dl_instr = buf_instr;
        dl_pc    = buf_pc;
      end
      default: deliver = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      drain_pc  <= 32'h0;
      buf_instr <= 32'h0;
      buf_pc    <= 32'h0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack_i) begin
            if (redir) begin
              pc <= redir_pc;
            end else begin
              pc <= pc + 32'd4;
              if (pa_pc_ifid_i) begin
                buf_instr <= imem_rdata_i;
                buf_pc    <= pc;
                state     <= S_HOLD;
              end
            end
          end else if (redir) begin
            drain_pc <= redir_pc;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (imem_ack_i) begin
            pc    <= redir ? redir_pc : drain_pc;
            state <= S_FETCH;
          end else if (redir) begin
            drain_pc <= redir_pc;
          end
        end
        S_HOLD: begin
          if (!pa_pc_ifid_i) begin
            if (redir) pc <= redir_pc;
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_o <= 32'h0;
      ifid_pc_o    <= 32'h0;
      ifid_valid_o <= 1'b0;
    end else if (pa_pc_ifid_i) begin
      ifid_instr_o <= ifid_instr_o;
    end else if (wash_ifid_i || !deliver) begin
      ifid_instr_o <= 32'h0;
      ifid_pc_o    <= 32'h0;
      ifid_valid_o <= 1'b0;
    end else begin
      ifid_instr_o <= dl_instr;
      ifid_pc_o    <= dl_pc;
      ifid_valid_o <= 1'b1;
    end
  end

  assign imem_addr_o   = pc;
  assign imem_req_o    = !rst
                       && (state == S_FETCH
                        || state == S_DRAIN);
  assign fetch_pause_o = !rst
                       && ((state == S_FETCH && !imem_ack_i)
                        || state == S_DRAIN);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a programmable-wait memory model.
// Instruction data is the fetch address XOR a fixed pattern.
module tb_fetch_unit;

  localparam logic [31:0] MAGIC = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        pa_pc_ifid;
  logic        wash_ifid;
  logic        bpu_redirect;
  logic [31:0] bpu_target;
  logic        cp0_redirect;
  logic [31:0] cp0_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        fetch_pause;

  logic [3:0]  wait_n;
  logic [3:0]  cnt;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .pa_pc_ifid_i   (pa_pc_ifid),
    .wash_ifid_i    (wash_ifid),
    .bpu_redirect_i (bpu_redirect),
    .bpu_target_i   (bpu_target),
    .cp0_redirect_i (cp0_redirect),
    .cp0_target_i   (cp0_target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_rdata_i   (imem_rdata),
    .ifid_instr_o   (ifid_instr),
    .ifid_pc_o      (ifid_pc),
    .ifid_valid_o   (ifid_valid),
    .fetch_pause_o  (fetch_pause)
  );

  // Memory acks after wait_n cycles of continuous request.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) cnt <= 4'd0;
    else cnt <= cnt + 4'd1;
  end

  assign imem_ack   = imem_req && (cnt >= wait_n);
  assign imem_rdata = imem_addr ^ MAGIC;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    pa_pc_ifid   = 1'b0;
    wash_ifid    = 1'b0;
    bpu_redirect = 1'b0;
    bpu_target   = 32'h0;
    cp0_redirect = 1'b0;
    cp0_target   = 32'h0;
    wait_n       = 4'd0;
    tick();
    tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_pause", {31'h0, fetch_pause}, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_pc", ifid_pc, 32'h0);
    check("rst_instr", ifid_instr, 32'h0);

    // zero-wait streaming
    rst = 1'b0;
    #1;
    check("zw_req", {31'h0, imem_req}, 32'h1);
    check("zw_addr0", imem_addr, 32'hBFC0_0000);
    check("zw_pause0", {31'h0, fetch_pause}, 32'h0);
    tick();
    check("zw_addr1", imem_addr, 32'hBFC0_0004);
    check("zw_ifpc0", ifid_pc, 32'hBFC0_0000);
    check("zw_valid0", {31'h0, ifid_valid}, 32'h1);
    check("zw_instr0", ifid_instr, 32'hBFC0_0000 ^ MAGIC);
    check("zw_pause1", {31'h0, fetch_pause}, 32'h0);
    tick();
    check("zw_addr2", imem_addr, 32'hBFC0_0008);
    check("zw_ifpc1", ifid_pc, 32'hBFC0_0004);
    check("zw_pause2", {31'h0, fetch_pause}, 32'h0);

    // 3-wait fetch of BFC00008
    wait_n = 4'd3;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("w3_pause", {31'h0, fetch_pause}, 32'h1);
      check("w3_addr", imem_addr, 32'hBFC0_0008);
      tick();
      check("w3_bubble", {31'h0, ifid_valid}, 32'h0);
    end
    check("w3_ackpause", {31'h0, fetch_pause}, 32'h0);
    tick();
    check("w3_ifpc", ifid_pc, 32'hBFC0_0008);
    check("w3_valid", {31'h0, ifid_valid}, 32'h1);
    check("w3_next", imem_addr, 32'hBFC0_000C);

    // redirect with same-cycle ack, then fetch 0xFC
    wait_n       = 4'd0;
    bpu_redirect = 1'b1;
    bpu_target   = 32'h0000_00FC;
    tick();
    bpu_redirect = 1'b0;
    check("ra_addr", imem_addr, 32'h0000_00FC);
    check("ra_bubble", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("fc_ifpc", ifid_pc, 32'h0000_00FC);
    check("fc_addr", imem_addr, 32'h0000_0100);

    // ack at 0x100 under a 4-cycle stall
    pa_pc_ifid = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_req", {31'h0, imem_req}, 32'h0);
      check("hold_ifpc", ifid_pc, 32'h0000_00FC);
      check("hold_valid", {31'h0, ifid_valid}, 32'h1);
      tick();
    end
    pa_pc_ifid = 1'b0;
    check("hold_req4", {31'h0, imem_req}, 32'h0);
    check("hold_pause", {31'h0, fetch_pause}, 32'h0);
    tick();
    check("rel_ifpc", ifid_pc, 32'h0000_0100);
    check("rel_instr", ifid_instr, 32'h0000_0100 ^ MAGIC);
    check("rel_valid", {31'h0, ifid_valid}, 32'h1);
    check("rel_addr", imem_addr, 32'h0000_0104);
    check("rel_req", {31'h0, imem_req}, 32'h1);

    // redirect to 0x400 while 0x200 still has 2 wait cycles left
    bpu_redirect = 1'b1;
    bpu_target   = 32'h0000_0200;
    tick();
    bpu_redirect = 1'b0;
    wait_n       = 4'd3;
    check("d_addr200", imem_addr, 32'h0000_0200);
    tick();
    bpu_redirect = 1'b1;
    bpu_target   = 32'h0000_0400;
    check("d_pause0", {31'h0, fetch_pause}, 32'h1);
    tick();
    bpu_redirect = 1'b0;
    check("d_pause1", {31'h0, fetch_pause}, 32'h1);
    check("d_addr", imem_addr, 32'h0000_0200);
    check("d_req", {31'h0, imem_req}, 32'h1);
    check("d_bub1", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("d_ackpause", {31'h0, fetch_pause}, 32'h1);
    check("d_bub2", {31'h0, ifid_valid}, 32'h0);
    tick();
    check("d_newaddr", imem_addr, 32'h0000_0400);
    check("d_discard", {31'h0, ifid_valid}, 32'h0);
    wait_n = 4'd0;
    tick();
    check("d_ifpc", ifid_pc, 32'h0000_0400);
    check("d_instr", ifid_instr, 32'h0000_0400 ^ MAGIC);
    check("d_valid", {31'h0, ifid_valid}, 32'h1);

    // cp0 + bpu + wash in one cycle, with ack
    cp0_redirect = 1'b1;
    cp0_target   = 32'h8000_0180;
    bpu_redirect = 1'b1;
    bpu_target   = 32'h0000_0500;
    wash_ifid    = 1'b1;
    tick();
    cp0_redirect = 1'b0;
    bpu_redirect = 1'b0;
    wash_ifid    = 1'b0;
    check("sim_addr", imem_addr, 32'h8000_0180);
    check("sim_valid", {31'h0, ifid_valid}, 32'h0);
    check("sim_pc", ifid_pc, 32'h0);
    check("sim_instr", ifid_instr, 32'h0);

    // PC wrap
    bpu_redirect = 1'b1;
    bpu_target   = 32'hFFFF_FFFC;
    tick();
    bpu_redirect = 1'b0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    check("wr_wrap", imem_addr, 32'h0);
    check("wr_ifpc", ifid_pc, 32'hFFFF_FFFC);
    tick();
    check("wr_ifpc0", ifid_pc, 32'h0);
    check("wr_addr4", imem_addr, 32'h4);

    // reset during S_DRAIN
    wait_n       = 4'd3;
    bpu_redirect = 1'b1;
    bpu_target   = 32'h0000_0600;
    tick();
    bpu_redirect = 1'b0;
    check("rd_pause", {31'h0, fetch_pause}, 32'h1);
    check("rd_addr", imem_addr, 32'h4);
    rst = 1'b1;
    #1;
    check("rd_req_c", {31'h0, imem_req}, 32'h0);
    check("rd_pause_c", {31'h0, fetch_pause}, 32'h0);
    tick();
    check("rd_valid", {31'h0, ifid_valid}, 32'h0);
    check("rd_pc", ifid_pc, 32'h0);
    check("rd_instr", ifid_instr, 32'h0);
    check("rd_pcreg", imem_addr, 32'hBFC0_0000);
    rst    = 1'b0;
    wait_n = 4'd0;
    #1;
    check("rd_req", {31'h0, imem_req}, 32'h1);
    check("rd_first", imem_addr, 32'hBFC0_0000);
    tick();
    check("rd_ifpc", ifid_pc, 32'hBFC0_0000);
    check("rd_next", imem_addr, 32'hBFC0_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
